// File: rtl/t_edge_counter_if.sv
// Bus bundle for t_edge_counter: toggle input, run control and status.
// The master side (the environment) drives q_in/start/clear/tc_value.
// The slave side (the counter) drives count/edge_seen/busy/done.
interface t_edge_counter_if #(
    parameter int W = 8
);
    logic         q_in;
    logic         start;
    logic         clear;
    logic [W-1:0] tc_value;
    logic [W-1:0] count;
    logic         edge_seen;
    logic         busy;
    logic         done;

    modport master (
        output q_in,
        output start,
        output clear,
        output tc_value,
        input  count,
        input  edge_seen,
        input  busy,
        input  done
    );

    modport slave (
        input  q_in,
        input  start,
        input  clear,
        input  tc_value,
        output count,
        output edge_seen,
        output busy,
        output done
    );
endinterface

// File: rtl/t_edge_counter.sv
// t_edge_counter: counts level changes of the asynchronous q output of the
// gated T latch stage. q_in is brought into the clk domain by a 2-flop
// synchronizer followed by a history flop; any difference between the last
// two synchronized samples is a toggle. Every toggle gives a registered
// one-cycle edge_seen pulse, and a small run FSM counts toggles up to a
// terminal count captured at start, then parks in DONE until restarted.
module t_edge_counter #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              reset,
    t_edge_counter_if.slave   bus
);

    // Run FSM encoding; 2'b11 is unused and recovers to IDLE.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_COUNT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // The mask must outlast the time a value held on q_in through reset
    // needs to reach s3: two edges fill s1/s2, a third lets s3 catch up,
    // so a level present at reset release never looks like a toggle.
    localparam logic [1:0] MASK_INIT = 2'd3;

    // Synchronizer + history
    logic         r_s1;
    logic         r_s2;
    logic         r_s3;
    logic [1:0]   r_mask;

    // Run state and datapath
    logic [1:0]   r_state;
    logic [W-1:0] r_count;
    logic [W-1:0] r_tc;

    // Registered outputs
    logic         r_edge_seen;
    logic         r_busy;
    logic         r_done;

    // Combinational next-state values
    logic         w_det;
    logic         w_det_q;
    logic [W:0]   w_count_inc;
    logic [1:0]   w_state_nxt;
    logic [W-1:0] w_count_nxt;
    logic [W-1:0] w_tc_nxt;

    // A toggle is a mismatch between the newest synchronized sample and the
    // one before it; it is only trusted once the post-reset mask expires.
    assign w_det   = r_s2 ^ r_s3;
    assign w_det_q = w_det & (r_mask == 2'd0);

    // One extra bit so the terminal-count compare can never alias on wrap.
    assign w_count_inc = {1'b0, r_count} + {{W{1'b0}}, 1'b1};

    // Synchronizer chain and history flop; keeps running under clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbour, forming a real chain.
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= bus.q_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Post-reset mask: counts down once and then stays at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= MASK_INIT;
        end else if (r_mask != 2'd0) begin
            r_mask <= r_mask - 2'd1;
        end
    end

    // Toggle pulse: one cycle per detected toggle, in every FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge_seen <= 1'b0;
        end else begin
            r_edge_seen <= w_det_q;
        end
    end

    // Next-state logic for the run FSM, count and terminal count.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_tc_nxt    = r_tc;

        if (bus.clear) begin
            // Abort: partial count discarded, terminal count retained.
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    // A toggle arriving with start out of DONE belongs to
                    // neither run, so det is not looked at here.
                    if (bus.start) begin
                        w_tc_nxt    = bus.tc_value;
                        w_count_nxt = '0;
                        w_state_nxt = (bus.tc_value == '0) ? ST_DONE : ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    // start is deliberately ignored while a run is active.
                    if (w_det_q) begin
                        w_count_nxt = w_count_inc[W-1:0];
                        if (w_count_inc == {1'b0, r_tc}) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Run FSM registers; busy/done are decoded from the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_tc    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_busy  <= (w_state_nxt == ST_COUNT);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.count     = r_count;
    assign bus.edge_seen = r_edge_seen;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
